fetch_unit_pq: RTL and testbench
================================

Name: fetch_unit_pq

Overview:
Parametrised successor to the single-instruction fetch unit. Holds a PC, issues reads to a synchronous 1-cycle-latency instruction memory, and buffers returned instructions in a DEPTH-entry prefetch queue. The queue feeds decode through a valid/ready handshake. Branches are absolute or PC-relative, flush the queue and discard any in-flight read. Sits between instruction ROM and decode.

Parameters:
PC_W, 8, PC and imem address width.
INSTR_W, 9, instruction width.
DEPTH, 4, prefetch queue entries; power of two, >=2.
RESET_PC, 0, PC loaded on reset.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
branch_ctrl  in  1  branch request, one-cycle pulse
branch_mode  in  1  0 = absolute target, 1 = PC-relative signed offset
branch_val  in  PC_W  target address or two's-complement offset
imem_addr  out  PC_W  instruction memory read address
imem_rd  out  1  read strobe; data returns the next cycle
imem_data  in  INSTR_W  read data, valid the cycle after imem_rd
instruction_val  out  INSTR_W  head-of-queue instruction
instr_pc  out  PC_W  PC of head instruction
instr_valid  out  1  head entry valid
instr_ready  in  1  decode accepts head when high together with instr_valid
queue_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC, last_pc=RESET_PC.
  - Queue empty, pending=0.
  - imem_rd=0, imem_addr=RESET_PC, instr_valid=0, instruction_val=0, instr_pc=0, queue_count=0.
- Reset asserted mid-operation: the in-flight read is abandoned. Its data is never written after reset releases.
- Issue rule: imem_rd=1 when count+pending < DEPTH and branch_ctrl=0.
  - imem_addr=fetch_pc.
  - On issue, fetch_pc increments modulo 2^PC_W (wraps 2^PC_W-1 -> 0) and pending=1 for the next cycle.
- Return: when pending=1, imem_data is written to the tail together with its PC at the clock edge ending that cycle.
- Latency: first imem_rd in cycle N -> instr_valid=1 in cycle N+2.
- Throughput: one instruction per cycle sustained when instr_ready stays high.
- Pop: when instr_valid & instr_ready, the head is removed and last_pc takes instr_pc.
- Push and pop in the same cycle: count is unchanged. A push into a full queue cannot occur, by the credit rule.
- instruction_val and instr_pc are combinational from the head entry. Both drive 0 when the queue is empty.
- instr_ready low: the head holds stable. Issue stops once count+pending=DEPTH.
- Branch (branch_ctrl=1):
  - target = branch_val (mode 0), or last_pc + sign_extend(branch_val) modulo 2^PC_W (mode 1).
  - At the edge: fetch_pc=target, queue cleared (count=0), pending=0. Any data returning the next cycle is dropped.
  - No issue in the branch cycle. The first read of target is in the cycle after, and instr_valid rises 2 cycles after that.
- Branch with a simultaneous pop: the branch wins. last_pc still updates from the popped entry, but the relative target uses the pre-edge last_pc.
- Back-to-back branches: the last one wins.
- queue_count always equals the number of valid entries.

Decomposition:
- Shared package: PC_W/INSTR_W defaults, RESET_PC, the BR_ABS/BR_REL mode constants, and the queue-entry typedef {pc, instr}.
- One sub-module, fetch_queue: a DEPTH-entry synchronous FIFO with a flush input.
  - Ports: push, pop, flush, count, head outputs, async active-low reset.
- The top level holds fetch_pc, last_pc, pending, credit logic and branch target arithmetic.

Test Plan:
1. Reset release, instr_ready=1, imem returns mem[a]=a+9'h100.
   - imem_rd rises in cycle 1 with addr 0.
   - instr_valid rises in cycle 3 with instruction_val=9'h100, instr_pc=0.
   - Then pc 1, 2, 3 follow on consecutive cycles.
2. instr_ready=0 from reset.
   - Exactly 4 reads are issued (addr 0-3), then queue_count=4 and imem_rd=0.
   - Raising instr_ready drains 0, 1, 2, 3 and fetching resumes at 4.
3. Absolute branch: branch_ctrl=1, mode=0, val=8'd3 while pc 5 is in flight.
   - Pc 5's data is dropped and queue_count=0 next cycle.
   - The next read is addr 3; the next valid instr_pc is 3.
4. Relative branch: last_pc=8'd10, mode=1, val=8'hFE (-2).
   - Next fetched addr is 8.
   - With last_pc=8'd255 and val=8'd2, the target wraps to 1.
5. PC wrap: RESET_PC=8'd254, free-running.
   - instr_pc sequence is 254, 255, 0, 1.
6. reset pulsed low mid-stream with pending=1 and queue_count=3.
   - All outputs go to reset values immediately and the stale data is not enqueued.
   - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pq_pkg.sv
// rtl/fetch_unit_pq_pkg.sv - shared widths, branch modes and queue-entry layout for fetch_unit_pq
package fetch_unit_pq_pkg;

  localparam int          PC_W_DEF     = 8;
  localparam int          INSTR_W_DEF  = 9;
  localparam int          DEPTH_DEF    = 4;
  localparam int unsigned RESET_PC_DEF = 0;

  localparam logic BR_ABS = 1'b0;
  localparam logic BR_REL = 1'b1;

  // Queue entry at default widths; the queue stores {pc, instr} in this order.
  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry synchronous prefetch FIFO with flush
module fetch_queue
  import fetch_unit_pq_pkg::*;
#(
  parameter int W     = PC_W_DEF + INSTR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_head_valid,
  output logic [W-1:0]             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Flush dominates so a read returning in a branch cycle is discarded.
  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != '0);
  assign o_head       = o_head_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit_pq.sv
// rtl/fetch_unit_pq.sv - PC, credit-based imem issue and branch handling in front of a prefetch queue
module fetch_unit_pq
  import fetch_unit_pq_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEF,
  parameter int          INSTR_W  = INSTR_W_DEF,
  parameter int          DEPTH    = DEPTH_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    branch_ctrl,
  input  logic                    branch_mode,
  input  logic [PC_W-1:0]         branch_val,
  output logic [PC_W-1:0]         imem_addr,
  output logic                    imem_rd,
  input  logic [INSTR_W-1:0]      imem_data,
  output logic [INSTR_W-1:0]      instruction_val,
  output logic [PC_W-1:0]         instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [$clog2(DEPTH):0]  queue_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_W + INSTR_W;
  localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_last_pc;
  logic [PC_W-1:0] r_pend_pc;
  logic            r_pending;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_inflight;
  logic            w_issue;
  logic            w_pop;
  logic            w_head_valid;
  logic [EW-1:0]   w_head;
  logic [PC_W-1:0] w_target;

  // A read in flight holds a queue slot, so a push can never find the queue full.
  assign w_inflight = w_count + CW'(r_pending);
  assign w_issue    = (w_inflight < DEPTH_C) && !branch_ctrl;
  assign imem_rd    = w_issue && reset;
  assign imem_addr  = r_fetch_pc;
  assign w_pop      = w_head_valid && instr_ready;

  // Same-width modular add is the sign-extended relative add.
  assign w_target = (branch_mode == BR_REL) ? (r_last_pc + branch_val) : branch_val;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= PC_RST;
      r_last_pc  <= PC_RST;
      r_pend_pc  <= PC_RST;
      r_pending  <= 1'b0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) begin
        r_pend_pc <= r_fetch_pc;
      end
      if (branch_ctrl) begin
        r_fetch_pc <= w_target;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(1);
      end
      if (w_pop) begin
        r_last_pc <= instr_pc;
      end
    end
  end

  fetch_queue #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk          (clock),
    .rst_n        (reset),
    .i_push       (r_pending),
    .i_data       ({r_pend_pc, imem_data}),
    .i_pop        (w_pop),
    .i_flush      (branch_ctrl),
    .o_count      (w_count),
    .o_head_valid (w_head_valid),
    .o_head       (w_head)
  );

  assign instr_valid     = w_head_valid;
  assign instr_pc        = w_head[EW-1:INSTR_W];
  assign instruction_val = w_head[INSTR_W-1:0];
  assign queue_count     = w_count;

endmodule

// File: tb/tb_fetch_unit_pq.sv
// tb/tb_fetch_unit_pq.sv - randomized self-checking bench for fetch_unit_pq
`timescale 1ns/1ps
module tb_fetch_unit_pq;
  import fetch_unit_pq_pkg::*;

  localparam int PW = 8;
  localparam int IW = 9;

  logic          clock       = 1'b0;
  logic          reset       = 1'b0;
  logic          branch_ctrl = 1'b0;
  logic          branch_mode = 1'b0;
  logic [PW-1:0] branch_val  = '0;
  logic          instr_ready = 1'b0;

  logic [PW-1:0] imem_addr,   imem_addr_w;
  logic          imem_rd,     imem_rd_w;
  logic [IW-1:0] imem_data = '0, imem_data_w = '0;
  logic [IW-1:0] instruction_val, instruction_val_w;
  logic [PW-1:0] instr_pc,    instr_pc_w;
  logic          instr_valid, instr_valid_w;
  logic [2:0]    queue_count, queue_count_w;

  logic [IW-1:0] rom [256];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  // Instruction ROM with one-cycle read latency for each instance.
  always @(posedge clock) begin
    if (imem_rd)   imem_data   <= rom[imem_addr];
    if (imem_rd_w) imem_data_w <= rom[imem_addr_w];
  end

  fetch_unit_pq u_dut (
    .clock(clock), .reset(reset), .branch_ctrl(branch_ctrl), .branch_mode(branch_mode),
    .branch_val(branch_val), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .instruction_val(instruction_val), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .queue_count(queue_count)
  );

  fetch_unit_pq #(.RESET_PC(254)) u_dut_wrap (
    .clock(clock), .reset(reset), .branch_ctrl(branch_ctrl), .branch_mode(branch_mode),
    .branch_val(branch_val), .imem_addr(imem_addr_w), .imem_rd(imem_rd_w), .imem_data(imem_data_w),
    .instruction_val(instruction_val_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(instr_ready), .queue_count(queue_count_w)
  );

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    branch_ctrl = 1'b0;
    step();
    step();
  endtask

  task automatic release_reset();
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_accept(output logic [PW-1:0] pc, output logic [IW-1:0] ins, output bit ok);
    ok = 1'b0;
    pc = '0;
    ins = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (instr_valid && instr_ready) begin
        pc = instr_pc;
        ins = instruction_val;
        ok = 1'b1;
      end
      step();
    end
  endtask

  task automatic test_reset();
    instr_ready = 1'b1;
    hold_reset();
    n_cmp++;
    if ({imem_rd, imem_addr, instr_valid, instruction_val, instr_pc, queue_count} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rd=%0b addr=%0h v=%0b ins=%0h pc=%0h cnt=%0d want all 0",
               imem_rd, imem_addr, instr_valid, instruction_val, instr_pc, queue_count);
    end
  endtask

  task automatic test_latency();
    logic [PW-1:0] ek;
    logic [IW-1:0] ei;
    release_reset();
    n_cmp++;
    if ({imem_rd, imem_addr, instr_valid} !== {1'b1, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL lat_cycle1: got rd=%0b addr=%0h v=%0b want rd=1 addr=0 v=0", imem_rd, imem_addr, instr_valid);
    end
    step();
    n_cmp++;
    if ({imem_rd, imem_addr, instr_valid} !== {1'b1, 8'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL lat_cycle2: got rd=%0b addr=%0h v=%0b want rd=1 addr=1 v=0", imem_rd, imem_addr, instr_valid);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      ek = 8'(k);
      ei = 9'h100 + 9'(k);
      n_cmp++;
      if ({instr_valid, instruction_val, instr_pc} !== {1'b1, ei, ek}) begin
        n_bad++;
        $display("FAIL lat_stream%0d: got v=%0b ins=%0h pc=%0h want v=1 ins=%0h pc=%0h",
                 k, instr_valid, instruction_val, instr_pc, ei, ek);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int nrd;
    bit addr_ok;
    logic [PW-1:0] pc;
    logic [IW-1:0] ins;
    bit ok;
    instr_ready = 1'b0;
    hold_reset();
    release_reset();
    nrd = 0;
    addr_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (imem_rd) begin
        if (imem_addr !== 8'(nrd)) addr_ok = 1'b0;
        nrd++;
      end
      step();
    end
    n_cmp++;
    if (nrd != 4 || !addr_ok) begin
      n_bad++;
      $display("FAIL bp_reads: got %0d reads in order=%0b want 4 reads addr 0-3", nrd, addr_ok);
    end
    n_cmp++;
    if ({queue_count, imem_rd} !== {3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL bp_full: got cnt=%0d rd=%0b want cnt=4 rd=0", queue_count, imem_rd);
    end
    instr_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      wait_accept(pc, ins, ok);
      n_cmp++;
      if (!ok || pc !== 8'(i) || ins !== rom[8'(i)]) begin
        n_bad++;
        $display("FAIL bp_drain%0d: got ok=%0b pc=%0h ins=%0h want pc=%0h ins=%0h", i, ok, pc, ins, 8'(i), rom[8'(i)]);
      end
    end
  endtask

  task automatic test_abs_branch();
    bit found;
    logic [PW-1:0] pc;
    logic [IW-1:0] ins;
    bit ok;
    instr_ready = 1'b1;
    hold_reset();
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_rd && imem_addr == 8'd5) found = 1'b1;
      step();
    end
    branch_ctrl = 1'b1;
    branch_mode = BR_ABS;
    branch_val = 8'd3;
    #1;
    n_cmp++;
    if (!found || imem_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL abs_branch_cycle: got found=%0b rd=%0b want found=1 rd=0", found, imem_rd);
    end
    step();
    branch_ctrl = 1'b0;
    #1;
    n_cmp++;
    if ({queue_count, imem_rd, imem_addr} !== {3'd0, 1'b1, 8'd3}) begin
      n_bad++;
      $display("FAIL abs_after: got cnt=%0d rd=%0b addr=%0h want cnt=0 rd=1 addr=3", queue_count, imem_rd, imem_addr);
    end
    step();
    n_cmp++;
    if ({queue_count, instr_valid} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL abs_drop: got cnt=%0d v=%0b want cnt=0 v=0", queue_count, instr_valid);
    end
    wait_accept(pc, ins, ok);
    n_cmp++;
    if (!ok || pc !== 8'd3 || ins !== rom[3]) begin
      n_bad++;
      $display("FAIL abs_first: got ok=%0b pc=%0h ins=%0h want pc=3 ins=%0h", ok, pc, ins, rom[3]);
    end
  endtask

  task automatic do_branch(input logic mode, input logic [PW-1:0] val);
    branch_ctrl = 1'b1;
    branch_mode = mode;
    branch_val = val;
    #1;
    step();
    branch_ctrl = 1'b0;
    #1;
  endtask

  task automatic test_rel_branch();
    logic [PW-1:0] pc;
    logic [IW-1:0] ins;
    bit ok;
    instr_ready = 1'b1;
    hold_reset();
    release_reset();
    pc = '0;
    for (int i = 0; i < 15 && pc != 8'd10; i++) wait_accept(pc, ins, ok);
    n_cmp++;
    if (pc !== 8'd10 || {instr_valid, instr_pc} !== {1'b1, 8'd11}) begin
      n_bad++;
      $display("FAIL rel_setup: got last=%0h head v=%0b pc=%0h want last=a head pc=b", pc, instr_valid, instr_pc);
    end
    do_branch(BR_REL, 8'hFE);
    n_cmp++;
    if ({imem_rd, imem_addr} !== {1'b1, 8'd8}) begin
      n_bad++;
      $display("FAIL rel_minus2: got rd=%0b addr=%0h want rd=1 addr=8", imem_rd, imem_addr);
    end
    instr_ready = 1'b0;
    step();
    step();
    do_branch(BR_REL, 8'd0);
    n_cmp++;
    if ({imem_rd, imem_addr} !== {1'b1, 8'd11}) begin
      n_bad++;
      $display("FAIL rel_last_from_pop: got rd=%0b addr=%0h want rd=1 addr=b", imem_rd, imem_addr);
    end
    instr_ready = 1'b1;
    do_branch(BR_ABS, 8'd250);
    pc = '0;
    for (int i = 0; i < 10 && pc != 8'd255; i++) wait_accept(pc, ins, ok);
    do_branch(BR_REL, 8'd2);
    n_cmp++;
    if (pc !== 8'd255 || {imem_rd, imem_addr} !== {1'b1, 8'd1}) begin
      n_bad++;
      $display("FAIL rel_wrap: got last=%0h rd=%0b addr=%0h want last=ff rd=1 addr=1", pc, imem_rd, imem_addr);
    end
    wait_accept(pc, ins, ok);
    n_cmp++;
    if (!ok || pc !== 8'd1 || ins !== rom[1]) begin
      n_bad++;
      $display("FAIL rel_wrap_first: got ok=%0b pc=%0h ins=%0h want pc=1 ins=%0h", ok, pc, ins, rom[1]);
    end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] got [4];
    logic [PW-1:0] ek;
    int n;
    instr_ready = 1'b1;
    hold_reset();
    n_cmp++;
    if ({imem_rd_w, imem_addr_w, instr_valid_w, instruction_val_w, instr_pc_w, queue_count_w}
        !== {1'b0, 8'd254, 1'b0, 9'd0, 8'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL wrap_reset: got rd=%0b addr=%0h v=%0b cnt=%0d want rd=0 addr=fe v=0 cnt=0",
               imem_rd_w, imem_addr_w, instr_valid_w, queue_count_w);
    end
    release_reset();
    n = 0;
    for (int i = 0; i < 4; i++) got[i] = 8'hAA;
    for (int i = 0; i < 20 && n < 4; i++) begin
      if (instr_valid_w) begin
        got[n] = instr_pc_w;
        n++;
      end
      step();
    end
    for (int j = 0; j < 4; j++) begin
      ek = 8'd254 + 8'(j);
      n_cmp++;
      if (got[j] !== ek) begin
        n_bad++;
        $display("FAIL wrap_seq%0d: got pc=%0h want pc=%0h", j, got[j], ek);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    logic [PW-1:0] pc;
    logic [IW-1:0] ins;
    bit ok;
    instr_ready = 1'b0;
    hold_reset();
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (queue_count == 3'd3 && !imem_rd) found = 1'b1;
      else step();
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (!found || {imem_rd, imem_addr, instr_valid, instruction_val, instr_pc, queue_count} !== 30'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got found=%0b rd=%0b addr=%0h v=%0b cnt=%0d want found=1 all 0",
               found, imem_rd, imem_addr, instr_valid, queue_count);
    end
    #1;
    reset = 1'b1;
    #1;
    step();
    n_cmp++;
    if ({queue_count, imem_addr} !== {3'd0, 8'd1}) begin
      n_bad++;
      $display("FAIL mid_reset_stale: got cnt=%0d addr=%0h want cnt=0 addr=1", queue_count, imem_addr);
    end
    instr_ready = 1'b1;
    wait_accept(pc, ins, ok);
    n_cmp++;
    if (!ok || pc !== 8'd0 || ins !== rom[0]) begin
      n_bad++;
      $display("FAIL mid_reset_restart: got ok=%0b pc=%0h ins=%0h want pc=0 ins=%0h", ok, pc, ins, rom[0]);
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] exp_next;
    logic [PW-1:0] last_m;
    logic [PW-1:0] pre_last;
    int n_acc;
    for (int a = 0; a < 256; a++) rom[a] = 9'($urandom);
    instr_ready = 1'b1;
    hold_reset();
    release_reset();
    exp_next = 8'd0;
    last_m = 8'd0;
    n_acc = 0;
    for (int c = 0; c < 600; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      branch_ctrl = ($urandom_range(0, 15) == 0);
      branch_mode = 1'($urandom_range(0, 1));
      branch_val = 8'($urandom);
      #1;
      n_cmp++;
      if (instr_valid !== (queue_count != 3'd0) || queue_count > 3'd4) begin
        n_bad++;
        $display("FAIL rnd_count c%0d: got v=%0b cnt=%0d want v=(cnt!=0) cnt<=4", c, instr_valid, queue_count);
      end
      if (!instr_valid) begin
        n_cmp++;
        if ({instruction_val, instr_pc} !== 17'd0) begin
          n_bad++;
          $display("FAIL rnd_empty_zero c%0d: got ins=%0h pc=%0h want 0", c, instruction_val, instr_pc);
        end
      end
      if (branch_ctrl) begin
        n_cmp++;
        if (imem_rd !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_branch_issue c%0d: got rd=%0b want 0", c, imem_rd);
        end
      end
      pre_last = last_m;
      if (instr_valid && instr_ready) begin
        n_cmp++;
        if (instr_pc !== exp_next || instruction_val !== rom[exp_next]) begin
          n_bad++;
          $display("FAIL rnd_pop c%0d: got pc=%0h ins=%0h want pc=%0h ins=%0h",
                   c, instr_pc, instruction_val, exp_next, rom[exp_next]);
        end
        last_m = exp_next;
        exp_next = exp_next + 8'd1;
        n_acc++;
      end
      if (branch_ctrl) begin
        exp_next = (branch_mode == BR_REL) ? (pre_last + branch_val) : branch_val;
      end
      step();
    end
    branch_ctrl = 1'b0;
    n_cmp++;
    if (n_acc < 100) begin
      n_bad++;
      $display("FAIL rnd_progress: got %0d accepts want >=100", n_acc);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 9'h100 + 9'(a);
    test_reset();
    test_latency();
    test_backpressure();
    test_abs_branch();
    test_rel_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
